// File: rtl/hist_eq_pkg.sv
// Shared types and constants for the histogram equalizer frame sequencer.
// Holds state encoding, m2 owner codes, default timing and the state-to-output decode.
package hist_eq_pkg;

   typedef enum logic [3:0] {
      ST_IDLE  = 4'd0,
      ST_HIST  = 4'd1,
      ST_GAP1  = 4'd2,
      ST_CDF   = 4'd3,
      ST_GAP2  = 4'd4,
      ST_MAP   = 4'd5,
      ST_GAP3  = 4'd6,
      ST_DONE  = 4'd7,
      ST_ERROR = 4'd8
   } state_e;

   localparam logic [1:0] M2_NONE = 2'b00;
   localparam logic [1:0] M2_HIST = 2'b01;
   localparam logic [1:0] M2_CDF  = 2'b10;
   localparam logic [1:0] M2_MAP  = 2'b11;

   localparam int unsigned SETTLE_DEF  = 2;
   localparam logic [15:0] TIMEOUT_DEF = 16'd4096;

   typedef struct packed {
      logic       hist_start;
      logic       cdf_start;
      logic       map_start;
      logic [1:0] m2_owner;
      logic       busy;
   } phase_out_t;

   // GAP states keep the preceding phase's owner so its last m2 write can retire.
   function automatic phase_out_t decode_state(input state_e st);
      phase_out_t o;
      o = '0;
      case (st)
         ST_HIST: begin o.hist_start = 1'b1; o.m2_owner = M2_HIST; o.busy = 1'b1; end
         ST_GAP1: begin o.m2_owner = M2_HIST; o.busy = 1'b1; end
         ST_CDF:  begin o.cdf_start = 1'b1; o.m2_owner = M2_CDF; o.busy = 1'b1; end
         ST_GAP2: begin o.m2_owner = M2_CDF; o.busy = 1'b1; end
         ST_MAP:  begin o.map_start = 1'b1; o.m2_owner = M2_MAP; o.busy = 1'b1; end
         ST_GAP3: begin o.m2_owner = M2_MAP; o.busy = 1'b1; end
         ST_DONE: begin o.busy = 1'b1; end
         default: ;
      endcase
      return o;
   endfunction

endpackage

// File: rtl/phase_watchdog.sv
// Per-phase cycle counter; flags expiry on the cycle the phase reaches its time budget.
module phase_watchdog #(
   parameter logic [15:0] TIMEOUT_CYCLES = 16'd4096
) (
   input  logic        i_clock,
   input  logic        i_rst_n,
   input  logic        i_clear,
   input  logic        i_enable,
   output logic [15:0] o_count,
   output logic        o_expired
);

   logic [15:0] r_count;

   always_ff @(posedge i_clock or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_count <= '0;
      end else if (i_clear) begin
         r_count <= '0;
      end else if (i_enable && (r_count != '1)) begin
         r_count <= r_count + 16'd1;
      end
   end

   assign o_count   = r_count;
   assign o_expired = i_enable && (r_count >= (TIMEOUT_CYCLES - 16'd1));

endmodule

// File: rtl/hist_eq_controller.sv
// Frame sequencer for the histogram equalizer: HIST -> CDF -> MAP with settle gaps,
// m2 ownership, input bank ping-pong and a per-phase watchdog.
module hist_eq_controller
   import hist_eq_pkg::*;
#(
   parameter int unsigned SETTLE_CYCLES  = SETTLE_DEF,
   parameter logic [15:0] TIMEOUT_CYCLES = TIMEOUT_DEF,
   parameter bit          PINGPONG       = 1'b1
) (
   input  logic        clock,
   input  logic        rst_n,
   input  logic        go,
   input  logic        abort,
   input  logic        hist_done,
   input  logic        cdf_done,
   input  logic        map_done,
   output logic        hist_start,
   output logic        cdf_start,
   output logic        map_start,
   output logic [1:0]  m2_owner,
   output logic        bank_sel,
   output logic        busy,
   output logic        frame_done,
   output logic        error,
   output logic [15:0] frame_count
);

   localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);

   state_e      r_state;
   state_e      w_next;
   phase_out_t  r_outs;
   logic        r_frame_done;
   logic        r_error;
   logic        r_bank;
   logic [15:0] r_frame_count;
   logic [15:0] r_settle;
   logic        w_in_phase;
   logic        w_in_gap;
   logic        w_settle_done;
   logic        w_wd_expired;
   logic [15:0] w_wd_count;

   assign w_in_phase    = (r_state == ST_HIST) || (r_state == ST_CDF) || (r_state == ST_MAP);
   assign w_in_gap      = (r_state == ST_GAP1) || (r_state == ST_GAP2) || (r_state == ST_GAP3);
   assign w_settle_done = w_in_gap && (r_settle == SETTLE_LAST);

   phase_watchdog #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_watchdog (
      .i_clock   (clock),
      .i_rst_n   (rst_n),
      .i_clear   (!w_in_phase),
      .i_enable  (w_in_phase),
      .o_count   (w_wd_count),
      .o_expired (w_wd_expired)
   );

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         r_settle <= '0;
      end else if (!w_in_gap) begin
         r_settle <= '0;
      end else begin
         r_settle <= r_settle + 16'd1;
      end
   end

   // Done is tested before expiry in each phase so a coincident done wins.
   always_comb begin
      w_next = r_state;
      unique case (r_state)
         ST_IDLE:  if (go)             w_next = ST_HIST;
         ST_HIST:  if (hist_done)      w_next = ST_GAP1;
                   else if (w_wd_expired) w_next = ST_ERROR;
         ST_GAP1:  if (w_settle_done)  w_next = ST_CDF;
         ST_CDF:   if (cdf_done)       w_next = ST_GAP2;
                   else if (w_wd_expired) w_next = ST_ERROR;
         ST_GAP2:  if (w_settle_done)  w_next = ST_MAP;
         ST_MAP:   if (map_done)       w_next = ST_GAP3;
                   else if (w_wd_expired) w_next = ST_ERROR;
         ST_GAP3:  if (w_settle_done)  w_next = ST_DONE;
         ST_DONE:                      w_next = ST_IDLE;
         ST_ERROR: if (go)             w_next = ST_HIST;
         default:                      w_next = ST_IDLE;
      endcase
      if (abort) begin
         w_next = ST_IDLE;
      end
   end

   // Outputs are registered from the next state so they change on the same edge as the state.
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= ST_IDLE;
         r_outs        <= '0;
         r_frame_done  <= 1'b0;
         r_error       <= 1'b0;
         r_bank        <= 1'b0;
         r_frame_count <= '0;
      end else begin
         r_state      <= w_next;
         r_outs       <= decode_state(w_next);
         r_frame_done <= (w_next == ST_DONE);
         r_error      <= (w_next == ST_ERROR);
         if (w_next == ST_DONE) begin
            r_frame_count <= r_frame_count + 16'd1;
            r_bank        <= r_bank ^ PINGPONG;
         end
      end
   end

   assign hist_start  = r_outs.hist_start;
   assign cdf_start   = r_outs.cdf_start;
   assign map_start   = r_outs.map_start;
   assign m2_owner    = r_outs.m2_owner;
   assign busy        = r_outs.busy;
   assign frame_done  = r_frame_done;
   assign error       = r_error;
   assign bank_sel    = r_bank;
   assign frame_count = r_frame_count;

   a_wd_bounded: assert property (@(posedge clock) disable iff (!rst_n)
      w_wd_count <= TIMEOUT_CYCLES);

endmodule

// File: tb/tb_hist_eq_controller.sv
// Directed bench for hist_eq_controller: one default-timeout instance and one with a 64-cycle watchdog.
module tb_hist_eq_controller;
   import hist_eq_pkg::*;

   logic        clock;
   logic        rst_n;
   logic        go;
   logic        abort;
   logic        hd;
   logic        cd;
   logic        md;

   logic        hs_a, cs_a, ms_a, bank_a, busy_a, fd_a, err_a;
   logic [1:0]  own_a;
   logic [15:0] cnt_a;
   logic        hs_b, cs_b, ms_b, bank_b, busy_b, fd_b, err_b;
   logic [1:0]  own_b;
   logic [15:0] cnt_b;

   int n_cmp = 0;
   int n_err = 0;

   // {hist_start, cdf_start, map_start, m2_owner, busy, frame_done, error}
   localparam logic [7:0] P_IDLE = 8'b000_00_000;
   localparam logic [7:0] P_HIST = 8'b100_01_100;
   localparam logic [7:0] P_GAP1 = 8'b000_01_100;
   localparam logic [7:0] P_CDF  = 8'b010_10_100;
   localparam logic [7:0] P_GAP2 = 8'b000_10_100;
   localparam logic [7:0] P_MAP  = 8'b001_11_100;
   localparam logic [7:0] P_GAP3 = 8'b000_11_100;
   localparam logic [7:0] P_DONE = 8'b000_00_110;
   localparam logic [7:0] P_ERR  = 8'b000_00_001;

   wire [7:0] obs_a = {hs_a, cs_a, ms_a, own_a, busy_a, fd_a, err_a};
   wire [7:0] obs_b = {hs_b, cs_b, ms_b, own_b, busy_b, fd_b, err_b};

   hist_eq_controller u_dut (
      .clock (clock), .rst_n (rst_n), .go (go), .abort (abort),
      .hist_done (hd), .cdf_done (cd), .map_done (md),
      .hist_start (hs_a), .cdf_start (cs_a), .map_start (ms_a),
      .m2_owner (own_a), .bank_sel (bank_a), .busy (busy_a),
      .frame_done (fd_a), .error (err_a), .frame_count (cnt_a)
   );

   hist_eq_controller #(
      .SETTLE_CYCLES (2), .TIMEOUT_CYCLES (16'd64), .PINGPONG (1'b1)
   ) u_dut_wd (
      .clock (clock), .rst_n (rst_n), .go (go), .abort (abort),
      .hist_done (hd), .cdf_done (cd), .map_done (md),
      .hist_start (hs_b), .cdf_start (cs_b), .map_start (ms_b),
      .m2_owner (own_b), .bank_sel (bank_b), .busy (busy_b),
      .frame_done (fd_b), .error (err_b), .frame_count (cnt_b)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      @(negedge clock);
   endtask

   task automatic hold(input int n, input logic [7:0] pat, inout int bad);
      for (int i = 0; i < n; i++) begin
         if (obs_a !== pat) bad++;
         tick();
      end
   endtask

   // Walk one frame on the default instance and stop at the IDLE cycle after DONE.
   task automatic run_frame(input string tag, input int lh, input int lc, input int lm,
                            input logic mid_go);
      int bad;
      bad = 0;
      go = 1'b1; tick(); go = 1'b0;
      hold(lh - 1, P_HIST, bad);
      if (obs_a !== P_HIST) bad++;
      hd = 1'b1; tick(); hd = 1'b0;
      hold(2, P_GAP1, bad);
      go = mid_go; hold(1, P_CDF, bad); go = 1'b0;
      hold(lc - 2, P_CDF, bad);
      if (obs_a !== P_CDF) bad++;
      cd = 1'b1; tick(); cd = 1'b0;
      hold(2, P_GAP2, bad);
      hold(lm - 1, P_MAP, bad);
      if (obs_a !== P_MAP) bad++;
      md = 1'b1; tick(); md = 1'b0;
      hold(2, P_GAP3, bad);
      check_val({tag, "_walk"}, 32'(bad), 32'd0);
      check_val({tag, "_done"}, {24'd0, obs_a}, {24'd0, P_DONE});
      tick();
      check_val({tag, "_idle"}, {24'd0, obs_a}, {24'd0, P_IDLE});
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: got hang expected finish");
      $fatal(1);
   end

   initial begin
      int   n;
      int   bad;
      logic saved_bank;
      logic [15:0] saved_cnt;

      rst_n = 1'b0; go = 1'b0; abort = 1'b0; hd = 1'b0; cd = 1'b0; md = 1'b0;
      tick(); tick();
      check_val("reset_outs", {7'd0, obs_a, bank_a, cnt_a}, 32'd0);
      rst_n = 1'b1;
      tick();
      check_val("idle_after_reset", {24'd0, obs_a}, {24'd0, P_IDLE});

      // Nominal frame
      run_frame("nominal", 130, 260, 520, 1'b0);
      check_val("nominal_count", {16'd0, cnt_a}, 32'd1);
      check_val("nominal_bank", {31'd0, bank_a}, 32'd1);

      // Back-to-back frames from reset, go pulsed during CDF each time
      rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
      run_frame("b2b1", 5, 6, 7, 1'b1);
      check_val("b2b1_bank", {31'd0, bank_a}, 32'd1);
      run_frame("b2b2", 5, 6, 7, 1'b1);
      check_val("b2b2_bank", {31'd0, bank_a}, 32'd0);
      run_frame("b2b3", 5, 6, 7, 1'b1);
      check_val("b2b3_bank", {31'd0, bank_a}, 32'd1);
      check_val("b2b3_count", {16'd0, cnt_a}, 32'd3);

      // Stray cdf_done during HIST, map_done held through GAP2
      bad = 0;
      go = 1'b1; tick(); go = 1'b0;
      cd = 1'b1; hold(3, P_HIST, bad); cd = 1'b0;
      if (obs_a !== P_HIST) bad++;
      hd = 1'b1; tick(); hd = 1'b0;
      hold(2, P_GAP1, bad);
      hold(2, P_CDF, bad);
      cd = 1'b1; tick(); cd = 1'b0;
      md = 1'b1;
      hold(2, P_GAP2, bad);
      check_val("stray_walk", 32'(bad), 32'd0);
      check_val("stray_map_entered", {24'd0, obs_a}, {24'd0, P_MAP});
      tick();
      check_val("stray_map_exit", {24'd0, obs_a}, {24'd0, P_GAP3});
      md = 1'b0;
      tick(); tick();
      check_val("stray_done", {24'd0, obs_a}, {24'd0, P_DONE});
      tick();

      // Watchdog timeout on the 64-cycle instance
      abort = 1'b1; tick(); abort = 1'b0;
      saved_bank = bank_b;
      go = 1'b1; tick(); go = 1'b0;
      repeat (2) tick();
      hd = 1'b1; tick(); hd = 1'b0;
      repeat (2) tick();
      n = 0;
      while (cs_b && n < 200) begin
         n++;
         tick();
      end
      check_val("wd_cdf_cycles", 32'(n), 32'd64);
      check_val("wd_error_outs", {24'd0, obs_b}, {24'd0, P_ERR});
      tick();
      check_val("wd_error_sticky", {31'd0, err_b}, 32'd1);
      go = 1'b1; tick(); go = 1'b0;
      check_val("wd_recover_hist", {24'd0, obs_b}, {24'd0, P_HIST});
      check_val("wd_recover_bank", {31'd0, bank_b}, {31'd0, saved_bank});
      check_val("wd_main_no_error", {24'd0, obs_a}, {24'd0, P_CDF});
      abort = 1'b1; tick(); abort = 1'b0;
      check_val("abort_clears_all", {16'd0, obs_a, obs_b}, {16'd0, P_IDLE, P_IDLE});

      // Abort in MAP
      saved_cnt = cnt_a;
      saved_bank = bank_a;
      go = 1'b1; tick(); go = 1'b0;
      repeat (2) tick(); hd = 1'b1; tick(); hd = 1'b0;
      repeat (3) tick(); cd = 1'b1; tick(); cd = 1'b0;
      repeat (3) tick();
      check_val("abort_in_map", {24'd0, obs_a}, {24'd0, P_MAP});
      abort = 1'b1; go = 1'b1; tick(); abort = 1'b0; go = 1'b0;
      check_val("abort_idle", {24'd0, obs_a}, {24'd0, P_IDLE});
      tick();
      check_val("abort_no_frame", {7'd0, obs_a, bank_a, cnt_a},
                {7'd0, P_IDLE, saved_bank, saved_cnt});

      // Async reset in CDF
      go = 1'b1; tick(); go = 1'b0;
      repeat (2) tick(); hd = 1'b1; tick(); hd = 1'b0;
      repeat (3) tick();
      check_val("rst_in_cdf_pre", {24'd0, obs_a}, {24'd0, P_CDF});
      #2 rst_n = 1'b0;
      #1 check_val("async_reset", {7'd0, obs_a, bank_a, cnt_a}, 32'd0);
      @(negedge clock);
      rst_n = 1'b1;
      tick();

      // Done and timeout coincide; frame_count wraps
      force u_dut.r_frame_count = 16'hFFFF;
      #1 release u_dut.r_frame_count;
      go = 1'b1; tick(); go = 1'b0;
      repeat (2) tick(); hd = 1'b1; tick(); hd = 1'b0;
      repeat (2) tick();
      repeat (63) tick();
      check_val("tie_last_cdf", {24'd0, obs_b}, {24'd0, P_CDF});
      cd = 1'b1; tick(); cd = 1'b0;
      check_val("tie_done_wins", {24'd0, obs_b}, {24'd0, P_GAP2});
      repeat (2) tick(); md = 1'b1; tick(); md = 1'b0;
      repeat (2) tick();
      check_val("wrap_done", {24'd0, obs_a}, {24'd0, P_DONE});
      check_val("wrap_count", {16'd0, cnt_a}, 32'd0);
      check_val("tie_frame_done", {31'd0, fd_b}, 32'd1);
      tick();
      check_val("wrap_idle", {24'd0, obs_a}, {24'd0, P_IDLE});

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
